// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single-precision divider (a / b).
// Restoring division yields one quotient bit per clock, then one cycle normalises and rounds.
module fp32_div_seq #(
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both high.
  // The producer holds its payload stable while valid is high and ready is low.
  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  exp_a, exp_b;
  logic        sign_q;
  logic        spec_exc, spec_zero;
  logic [24:0] rem;
  logic [23:0] div;
  logic [25:0] quo;
  logic [4:0]  iter;

  logic        in_exc, in_zero;
  logic [24:0] rem_sub;
  logic        rem_ge;

  logic [9:0]  e_n, e_r;
  logic [22:0] m_n;
  logic [23:0] m_r;
  logic        guard, sticky, round_up;
  logic        norm_ovf, norm_unf;

  assign in_exc  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || (b[30:23] == 8'h00);
  assign in_zero = !in_exc && (a[30:23] == 8'h00);

  assign rem_sub = rem - {1'b0, div};
  assign rem_ge  = (rem >= {1'b0, div});

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = ((in_exc || in_zero) && BYPASS_SPECIAL) ? NORM : CALC;
      CALC: if (iter == 5'd25) state_next = NORM;
      NORM: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quotient q[25] set means a's mantissa >= b's, so the leading one sits one place higher.
  always_comb begin
    if (quo[25]) begin
      m_n    = quo[24:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      e_n    = {2'b00, exp_a} - {2'b00, exp_b} + 10'd127;
    end else begin
      m_n    = quo[23:1];
      guard  = quo[0];
      sticky = |rem;
      e_n    = {2'b00, exp_a} - {2'b00, exp_b} + 10'd126;
    end
    round_up = guard & (sticky | m_n[0]);
    m_r      = {1'b0, m_n} + {23'd0, round_up};
    e_r      = m_r[23] ? e_n + 10'd1 : e_n;
    norm_ovf = ($signed(e_r) >= 10'sd255);
    norm_unf = ($signed(e_r) <= 10'sd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_a     <= '0;
      exp_b     <= '0;
      sign_q    <= 1'b0;
      spec_exc  <= 1'b0;
      spec_zero <= 1'b0;
      rem       <= '0;
      div       <= '0;
      quo       <= '0;
      iter      <= '0;
      result    <= '0;
      exception <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          exp_a     <= a[30:23];
          exp_b     <= b[30:23];
          sign_q    <= a[31] ^ b[31];
          spec_exc  <= in_exc;
          spec_zero <= in_zero;
          rem       <= {2'b01, a[22:0]};
          div       <= {1'b1, b[22:0]};
          quo       <= '0;
          iter      <= '0;
          result    <= '0;
          exception <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        CALC: begin
          // Remainder stays below the divisor after each step, so the shift never loses a bit.
          if (rem_ge) begin
            rem <= {rem_sub[23:0], 1'b0};
            quo <= {quo[24:0], 1'b1};
          end else begin
            rem <= {rem[23:0], 1'b0};
            quo <= {quo[24:0], 1'b0};
          end
          iter <= iter + 5'd1;
        end
        NORM: begin
          if (spec_exc) begin
            result    <= 32'hFFFF_FFFF;
            exception <= 1'b1;
          end else if (spec_zero) begin
            result <= 32'h0000_0000;
          end else if (norm_ovf) begin
            result   <= 32'hFFFF_FFFF;
            overflow <= 1'b1;
          end else if (norm_unf) begin
            result    <= 32'h0000_0000;
            underflow <= 1'b1;
          end else begin
            result <= {sign_q, e_r[7:0], m_r[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
